// File: rtl/gift_dec_ctrl.sv
// GIFT-128 decryption controller: captures ciphertext and key, rolls the key
// schedule forward 39 steps, then drives 40 inverse rounds through an external datapath.
module gift_dec_ctrl (
    input  logic         inClk,
    input  logic         inReset,
    input  logic         inStart,
    input  logic [127:0] inData,
    input  logic [127:0] inKey,
    input  logic [127:0] inRoundData,
    output logic         outReady,
    output logic         outValid,
    output logic [127:0] outData,
    output logic [5:0]   outRound,
    output logic [127:0] outRoundData,
    output logic [135:0] outRoundKey
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic [5:0]   const_q, const_d;
    logic [5:0]   count_q, count_d;
    logic [5:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;

    function automatic logic [127:0] key_fwd(input logic [127:0] k);
        logic [15:0] k1;
        logic [15:0] k0;
        k1 = k[31:16];
        k0 = k[15:0];
        return {k1[1:0], k1[15:2], k0[11:0], k0[15:12], k[127:32]};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k);
        logic [15:0] k7;
        logic [15:0] k6;
        k7 = k[127:112];
        k6 = k[111:96];
        return {k[95:0], k7[13:0], k7[15:14], k6[3:0], k6[15:4]};
    endfunction

    function automatic logic [5:0] lfsr_fwd(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [5:0] lfsr_inv(input logic [5:0] c);
        return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
    endfunction

    // Next-state and datapath control for the four-phase sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        out_d   = out_q;
        const_d = const_q;
        count_d = count_q;
        round_d = round_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inStart) begin
                    data_d  = inData;
                    key_d   = inKey;
                    const_d = 6'h01;
                    count_d = 6'd0;
                    state_d = ST_EXPAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                key_d   = key_fwd(key_q);
                const_d = lfsr_fwd(const_q);
                count_d = count_q + 6'd1;
                if (count_q == 6'd38) begin
                    round_d = 6'd40;
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            ST_ROUND: begin
                data_d = inRoundData;
                // Round 1 already uses the master key, so the schedule stops rolling back here.
                if (round_q == 6'd1) begin
                    out_d   = inRoundData;
                    round_d = 6'd0;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    key_d   = key_inv(key_q);
                    const_d = lfsr_inv(const_q);
                    round_d = round_q - 6'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Register bank with synchronous active-high reset.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_q <= ST_IDLE;
            data_q  <= 128'd0;
            key_q   <= 128'd0;
            out_q   <= 128'd0;
            const_q <= 6'd0;
            count_q <= 6'd0;
            round_q <= 6'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            out_q   <= out_d;
            const_q <= const_d;
            count_q <= count_d;
            round_q <= round_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign outReady     = ready_q;
    assign outValid     = valid_q;
    assign outData      = out_q;
    assign outRound     = round_q;
    assign outRoundData = data_q;
    assign outRoundKey  = {key_q, 2'b00, const_q};

endmodule

// File: tb/tb_gift_dec_ctrl.sv
// Bench for gift_dec_ctrl: supplies a GIFT-128 inverse round and checks round trips
// against an encryption model, plus timing, reset and busy-input behaviour.
module tb_gift_dec_ctrl;

    logic         inClk;
    logic         inReset;
    logic         inStart;
    logic [127:0] inData;
    logic [127:0] inKey;
    logic [127:0] inRoundData;
    logic         outReady;
    logic         outValid;
    logic [127:0] outData;
    logic [5:0]   outRound;
    logic [127:0] outRoundData;
    logic [135:0] outRoundKey;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit hold_start = 1'b0;

    gift_dec_ctrl dut (
        .inClk        (inClk),
        .inReset      (inReset),
        .inStart      (inStart),
        .inData       (inData),
        .inKey        (inKey),
        .inRoundData  (inRoundData),
        .outReady     (outReady),
        .outValid     (outValid),
        .outData      (outData),
        .outRound     (outRound),
        .outRoundData (outRoundData),
        .outRoundKey  (outRoundKey)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    // Free-running edge counter used to time acceptances.
    always @(posedge inClk) cyc <= cyc + 1;

    // ---------------- GIFT-128 reference model ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h1;  4'h1: return 4'ha;  4'h2: return 4'h4;  4'h3: return 4'hc;
            4'h4: return 4'h6;  4'h5: return 4'hf;  4'h6: return 4'h3;  4'h7: return 4'h9;
            4'h8: return 4'h2;  4'h9: return 4'hd;  4'ha: return 4'hb;  4'hb: return 4'h7;
            4'hc: return 4'h5;  4'hd: return 4'h0;  4'he: return 4'h8;  default: return 4'he;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] r = 4'h0;
        for (int v = 0; v < 16; v++) if (sbox(4'(v)) == x) r = 4'(v);
        return r;
    endfunction

    function automatic int pidx(input int i);
        return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    function automatic logic [127:0] rk_mask(input logic [127:0] k, input logic [5:0] c);
        logic [127:0] m = 128'd0;
        for (int i = 0; i < 32; i++) begin
            m[4*i+2] = k[64+i];
            m[4*i+1] = k[i];
        end
        for (int j = 0; j < 6; j++) m[4*j+3] = c[j];
        m[127] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k);
        logic [15:0] w [8];
        logic [15:0] n [8];
        logic [127:0] r;
        for (int i = 0; i < 8; i++) w[i] = k[16*i +: 16];
        n[7] = (w[1] >> 2) | (w[1] << 14);
        n[6] = (w[0] >> 12) | (w[0] << 4);
        for (int i = 0; i < 6; i++) n[i] = w[i+2];
        for (int i = 0; i < 8; i++) r[16*i +: 16] = n[i];
        return r;
    endfunction

    function automatic logic [5:0] const_step(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [127:0] key_at(input logic [127:0] k, input int n);
        logic [127:0] r = k;
        for (int i = 0; i < n; i++) r = key_step(r);
        return r;
    endfunction

    function automatic logic [5:0] const_at(input int n);
        logic [5:0] c = 6'h01;
        for (int i = 0; i < n; i++) c = const_step(c);
        return c;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt;
        logic [127:0] t;
        logic [127:0] k = key;
        logic [5:0]   c = 6'h01;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 32; i++) s[4*i +: 4] = sbox(s[4*i +: 4]);
            for (int i = 0; i < 128; i++) t[pidx(i)] = s[i];
            s = t ^ rk_mask(k, c);
            k = key_step(k);
            c = const_step(c);
        end
        return s;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s_in, input logic [135:0] rk);
        logic [127:0] s;
        logic [127:0] t;
        s = s_in ^ rk_mask(rk[135:8], rk[5:0]);
        for (int i = 0; i < 128; i++) t[i] = s[pidx(i)];
        for (int i = 0; i < 32; i++) t[4*i +: 4] = inv_sbox(t[4*i +: 4]);
        return t;
    endfunction

    assign inRoundData = inv_round(outRoundData, outRoundKey);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 136'(outReady), 136'(1));
        chk({tag, "_valid"}, 136'(outValid), 136'(0));
        chk({tag, "_round"}, 136'(outRound), 136'(0));
        chk({tag, "_data"},  136'(outData), 136'(0));
        chk({tag, "_rdata"}, 136'(outRoundData), 136'(0));
        chk({tag, "_rkey"},  outRoundKey, 136'(0));
    endtask

    task automatic start_only(input logic [127:0] ct, input logic [127:0] key, output int acc);
        int waited = 0;
        @(negedge inClk);
        while (outReady !== 1'b1 && waited < 200) begin
            @(negedge inClk);
            waited++;
        end
        chk("ready_before_start", 136'(outReady), 136'(1));
        inStart = 1'b1;
        inData  = ct;
        inKey   = key;
        @(posedge inClk);
        #1;
        acc = cyc;
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt, input bit detail, output int acc);
        bit        bad = 1'b0;
        logic [5:0] exp_round;
        logic       exp_valid;
        start_only(ct, key, acc);
        for (int k = 1; k <= 80; k++) begin
            @(negedge inClk);
            inStart = hold_start;
            inData  = rnd128();
            inKey   = rnd128();
            @(posedge inClk);
            #1;
            exp_round = (k >= 39 && k <= 78) ? 6'(79 - k) : 6'd0;
            exp_valid = (k == 79);
            if (detail) begin
                chk("round_idx", 136'(outRound), 136'(exp_round));
                chk("valid_pulse", 136'(outValid), 136'(exp_valid));
                chk("rkey_pad", 136'(outRoundKey[7:6]), 136'(0));
                if (exp_round != 6'd0) begin
                    chk("const_trace", 136'(outRoundKey[5:0]), 136'(const_at(int'(exp_round) - 1)));
                    chk("key_trace", 136'(outRoundKey[135:8]), 136'(key_at(key, int'(exp_round) - 1)));
                end
            end else begin
                if (outRound !== exp_round || outValid !== exp_valid || outRoundKey[7:6] !== 2'b00)
                    bad = 1'b1;
            end
            if (k == 79) begin
                chk("plaintext", 136'(outData), 136'(pt));
                chk("key_restored", 136'(outRoundKey[135:8]), 136'(key));
                chk("const_restored", 136'(outRoundKey[5:0]), 136'(6'h01));
            end
            if (k == 80) begin
                chk("ready_after_done", 136'(outReady), 136'(1));
                chk("valid_one_cycle", 136'(outValid), 136'(0));
                chk("data_hold", 136'(outData), 136'(pt));
            end
        end
        if (!detail) chk("block_protocol", 136'(bad), 136'(0));
    endtask

    task automatic abort_test(input int abort_k, input logic [5:0] exp_round_at_abort);
        logic [127:0] pt;
        logic [127:0] key;
        int acc;
        bit stale = 1'b0;
        pt  = rnd128();
        key = rnd128();
        start_only(encrypt(pt, key), key, acc);
        for (int k = 1; k <= abort_k; k++) begin
            @(negedge inClk);
            inStart = 1'b0;
            @(posedge inClk);
            #1;
        end
        chk("round_at_abort", 136'(outRound), 136'(exp_round_at_abort));
        @(negedge inClk);
        inReset = 1'b1;
        @(posedge inClk);
        #1;
        chk_all_zero("abort_reset");
        @(negedge inClk);
        inReset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge inClk);
            #1;
            if (outValid !== 1'b0 || outReady !== 1'b1) stale = 1'b1;
        end
        chk("no_stale_valid", 136'(stale), 136'(0));
        pt  = rnd128();
        key = rnd128();
        run_block(encrypt(pt, key), key, pt, 1'b1, acc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct2;
        logic [127:0] pt2;
        logic [127:0] key2;
        int a1;
        int a2;

        inReset = 1'b1;
        inStart = 1'b0;
        inData  = 128'd0;
        inKey   = 128'd0;
        repeat (3) @(posedge inClk);
        #1;
        chk_all_zero("reset");
        @(negedge inClk);
        inReset = 1'b0;
        @(posedge inClk);
        #1;
        chk("ready_after_release", 136'(outReady), 136'(1));

        // Reset and start on the same edge.
        @(negedge inClk);
        inReset = 1'b1;
        inStart = 1'b1;
        inData  = rnd128();
        inKey   = rnd128();
        @(posedge inClk);
        #1;
        chk_all_zero("reset_vs_start");
        @(negedge inClk);
        inReset = 1'b0;
        inStart = 1'b0;
        @(posedge inClk);
        #1;
        chk("idle_after_rs", 136'(outReady), 136'(1));
        chk("round_after_rs", 136'(outRound), 136'(0));

        // All-zero key and plaintext.
        run_block(encrypt(128'd0, 128'd0), 128'd0, 128'd0, 1'b1, a1);

        // Random vector with full per-cycle trace.
        pt  = rnd128();
        key = rnd128();
        run_block(encrypt(pt, key), key, pt, 1'b1, a1);

        // Start held high: back-to-back acceptances, busy inputs toggling.
        hold_start = 1'b1;
        pt   = rnd128();
        key  = rnd128();
        pt2  = rnd128();
        key2 = rnd128();
        ct2  = encrypt(pt2, key2);
        run_block(encrypt(pt, key), key, pt, 1'b0, a1);
        run_block(ct2, key2, pt2, 1'b0, a2);
        chk("accept_spacing", 136'(a2 - a1), 136'(81));
        hold_start = 1'b0;
        @(negedge inClk);
        inStart = 1'b0;

        // Aborts mid-expand and at round 20.
        abort_test(10, 6'd0);
        abort_test(59, 6'd20);

        // Random round trips.
        for (int v = 0; v < 300; v++) begin
            pt  = rnd128();
            key = rnd128();
            run_block(encrypt(pt, key), key, pt, 1'b0, a1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
